// File: rtl/delay_count_timer.sv
// delay_count_timer: serial 4-bit delay load, then (delay+1)*CYCLES_PER_UNIT cycle countdown.
// Optional sticky protocol error flag `err` when DELAY_COUNT_TIMER_ERR_EN is defined.
module delay_count_timer #(
   parameter int unsigned CYCLES_PER_UNIT = 1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       data,
   input  logic       shift_ena,
   input  logic       counting,
   input  logic       ack,
`ifdef DELAY_COUNT_TIMER_ERR_EN
   output logic       err,
`endif
   output logic [3:0] count,
   output logic       done_counting
);

   localparam int unsigned SW =
      (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
   localparam logic [SW-1:0] SUB_MAX = SW'(CYCLES_PER_UNIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      EXPIRED
   } phase_e;

   phase_e          phase_q, phase_d;
   logic [3:0]      delay_q, delay_d;
   logic [SW-1:0]   sub_q, sub_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= IDLE;
         delay_q <= 4'd0;
         sub_q   <= '0;
      end else begin
         phase_q <= phase_d;
         delay_q <= delay_d;
         sub_q   <= sub_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      delay_d = delay_q;
      sub_d   = sub_q;
      if (shift_ena) begin
         delay_d = {delay_q[2:0], data};
         sub_d   = SUB_MAX;
         phase_d = LOAD;
      end else if (counting) begin
         unique case (phase_q)
            LOAD, RUN: begin
               phase_d = RUN;
               if (sub_q != '0) begin
                  sub_d = sub_q - 1'b1;
               end else if (delay_q != 4'd0) begin
                  delay_d = delay_q - 4'd1;
                  sub_d   = SUB_MAX;
               end else begin
                  phase_d = EXPIRED;
               end
            end
            // Registers are already zero here, so this is an immediate expiry.
            IDLE, EXPIRED: phase_d = EXPIRED;
            default:       phase_d = IDLE;
         endcase
      end else if (phase_q == EXPIRED) begin
         phase_d = IDLE;
      end
   end

   assign count         = delay_q;
   assign done_counting = counting & (delay_q == 4'd0) & (sub_q == '0);

`ifdef DELAY_COUNT_TIMER_ERR_EN
   logic       err_q, err_d;
   logic       cnt_q;
   logic [2:0] shrun_q, shrun_d;
   logic       err_set;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q   <= 1'b0;
         cnt_q   <= 1'b0;
         shrun_q <= 3'd0;
      end else begin
         err_q   <= err_d;
         cnt_q   <= counting;
         shrun_q <= shrun_d;
      end
   end

   // Run length of shift_ena saturates at 4; any further shift cycle is an error.
   always_comb begin
      shrun_d = 3'd0;
      if (shift_ena)
         shrun_d = (shrun_q == 3'd4) ? shrun_q : shrun_q + 3'd1;
      err_set = (shift_ena & counting)
              | (shift_ena & (shrun_q == 3'd4))
              | (counting & ~cnt_q & (phase_q == IDLE));
      err_d = err_q;
      if (err_set)
         err_d = 1'b1;
      else if (ack)
         err_d = 1'b0;
   end

   assign err = err_q;
`else
   logic unused_ack;
   assign unused_ack = ack;
`endif

endmodule

// File: tb/tb_delay_count_timer.sv
// tb_delay_count_timer: directed plus random stimulus, scoreboard against a
// cycle-count reference model; two DUTs (CYCLES_PER_UNIT 4 and 1) share inputs.
module tb_delay_count_timer;

   localparam int CA = 4;
   localparam int CB = 1;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       data = 1'b0;
   logic       shift_ena = 1'b0;
   logic       counting = 1'b0;
   logic       ack = 1'b0;
   logic [3:0] count_a, count_b;
   logic       done_a, done_b;
   logic       err_a, err_b;

   always #5 clk = ~clk;

   delay_count_timer #(.CYCLES_PER_UNIT(CA)) u_a (
      .clk(clk), .reset_n(reset_n), .data(data),
      .shift_ena(shift_ena), .counting(counting), .ack(ack),
`ifdef DELAY_COUNT_TIMER_ERR_EN
      .err(err_a),
`endif
      .count(count_a), .done_counting(done_a)
   );

   delay_count_timer #(.CYCLES_PER_UNIT(CB)) u_b (
      .clk(clk), .reset_n(reset_n), .data(data),
      .shift_ena(shift_ena), .counting(counting), .ack(ack),
`ifdef DELAY_COUNT_TIMER_ERR_EN
      .err(err_b),
`endif
      .count(count_b), .done_counting(done_b)
   );

`ifndef DELAY_COUNT_TIMER_ERR_EN
   assign err_a = 1'b0;
   assign err_b = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] ca;
      logic [3:0] cb;
      logic       da;
      logic       db;
      logic       ea;
      logic       eb;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Reference model: delay loaded, counting cycles elapsed since load.
   int m_cpu[2] = '{CA, CB};
   bit m_loaded[2];
   int m_dly[2];
   int m_e[2];
   bit m_err[2];
   bit m_prevc;
   int m_shrun;

   function automatic int m_count(int k);
      if (m_loaded[k]) return m_dly[k] - m_e[k] / m_cpu[k];
      return m_dly[k];
   endfunction

   function automatic bit m_done(int k, bit c);
      if (!c) return 1'b0;
      if (!m_loaded[k]) return 1'b1;
      return (m_e[k] + 1) >= (m_dly[k] + 1) * m_cpu[k];
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_loaded[k] = 1'b0;
         m_dly[k] = 0;
         m_e[k] = 0;
         m_err[k] = 1'b0;
      end
      m_prevc = 1'b0;
      m_shrun = 0;
   endtask

   task automatic m_update(bit sh, bit d, bit c, bit a);
      for (int k = 0; k < 2; k++) begin
         bit set;
         int cur;
         set = (sh && c) || (sh && m_shrun >= 4) ||
               (c && !m_prevc && !m_loaded[k]);
         if (set) m_err[k] = 1'b1;
         else if (a) m_err[k] = 1'b0;
         if (sh) begin
            cur = m_count(k);
            m_dly[k] = ((cur * 2) + int'(d)) % 16;
            m_e[k] = 0;
            m_loaded[k] = 1'b1;
         end else if (c && m_loaded[k]) begin
            if (m_done(k, 1'b1)) begin
               m_loaded[k] = 1'b0;
               m_dly[k] = 0;
               m_e[k] = 0;
            end else begin
               m_e[k]++;
            end
         end
      end
      m_shrun = sh ? m_shrun + 1 : 0;
      m_prevc = c;
   endtask

   task automatic check(string nm, int cy, logic [31:0] act, logic [31:0] exv);
      checks++;
      if (act !== exv) begin
         failures++;
         $display("FAIL %s cyc=%0d act=%0d exp=%0d", nm, cy, act, exv);
      end
   endtask

   // Drive one cycle's inputs after the edge, record expectation, advance model.
   task automatic step(bit rn, bit sh, bit d, bit c, bit a);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n = rn;
      shift_ena = sh;
      data = d;
      counting = c;
      ack = a;
      cyc++;
      if (!rn) m_reset();
      e.ca = 4'(m_count(0));
      e.cb = 4'(m_count(1));
      e.da = m_done(0, c);
      e.db = m_done(1, c);
      e.ea = m_err[0];
      e.eb = m_err[1];
      e.cyc = cyc;
      q.push_back(e);
      if (rn) m_update(sh, d, c, a);
   endtask

   task automatic shift4(logic [3:0] v);
      for (int i = 3; i >= 0; i--) step(1'b1, 1'b1, v[i], 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("count_a", e.cyc, 32'(count_a), 32'(e.ca));
            check("count_b", e.cyc, 32'(count_b), 32'(e.cb));
            check("done_a", e.cyc, 32'(done_a), 32'(e.da));
            check("done_b", e.cyc, 32'(done_b), 32'(e.db));
`ifdef DELAY_COUNT_TIMER_ERR_EN
            check("err_a", e.cyc, 32'(err_a), 32'(e.ea));
            check("err_b", e.cyc, 32'(err_b), 32'(e.eb));
`endif
         end
      end
   end

   initial begin : driver
      int n;
      int tot;
      int ncnt;
      int nsh;
      m_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Nominal: delay 13, done in counting cycle 56.
      shift4(4'b1101);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("load13", cyc, 32'(count_a), 32'd13);
      n = 0;
      while (n < 200) begin
         n++;
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         #1;
         if (done_a) break;
      end
      check("nominal_cycles", cyc, n, 56);
      check("nominal_count0", cyc, 32'(count_a), 32'd0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Delay 0 on the 1-cycle-per-unit instance: immediate, sticky, no wrap.
      shift4(4'b0000);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         #1;
         check("zero_done_b", cyc, 32'(done_b), 32'd1);
         check("zero_cnt_b", cyc, 32'(count_b), 32'd0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Pause: delay 2, 3 counting, 5 paused, done 17 cycles after start.
      shift4(4'b0010);
      tot = 0;
      repeat (3) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         tot++;
      end
      repeat (5) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         tot++;
         #1 check("pause_frozen", cyc, 32'(count_a), 32'd2);
      end
      n = 0;
      while (n < 100) begin
         n++;
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         tot++;
         #1;
         if (done_a) break;
      end
      check("pause_total", cyc, tot, 17);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Async reset mid-run, then a nominal delay-3 load.
      shift4(4'b1001);
      repeat (10) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("rst_count", cyc, 32'(count_a), 32'd0);
      check("rst_done", cyc, 32'(done_a), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      shift4(4'b0011);
      n = 0;
      while (n < 100) begin
         n++;
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         #1;
         if (done_a) break;
      end
      check("post_rst_cycles", cyc, n, 16);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Abort by reload while paused in RUN.
      shift4(4'b0101);
      repeat (7) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      shift4(4'b0001);
      n = 0;
      while (n < 100) begin
         n++;
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         #1;
         if (done_a) break;
      end
      check("abort_cycles", cyc, n, 2 * CA);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef DELAY_COUNT_TIMER_ERR_EN
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("err_set", cyc, 32'(err_a), 32'd1);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("err_held", cyc, 32'(err_a), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("err_clr", cyc, 32'(err_a), 32'd0);
`endif

      // Random commands with pauses, overlaps, long shifts, resets, acks.
      repeat (60) begin
         if ($urandom_range(0, 9) == 0) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         nsh = ($urandom_range(0, 7) == 0) ? 5 : 4;
         for (int i = 0; i < nsh; i++)
            step(1'b1, 1'b1, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
         ncnt = $urandom_range(5, 80);
         for (int i = 0; i < ncnt; i++)
            step(1'b1, 1'b0, 1'b0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 5) == 0);
      end

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("queue_drained", cyc, q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
